// File: rtl/irr_isr_priority_resolver_if.sv
// Bundle between the CPU-side controller and the IRR/ISR priority resolver.
// master: drives requests, mask, vector base, INTA and EOI; slave: the resolver.
// Inputs : init, ir[7:0], ltim, imr[7:0], base[7:0], inta_n, eoi
//          (auto_rotate only with PIC_AUTO_ROTATE_EN)
// Outputs: irr[7:0], isr[7:0], highest_priority[2:0], int_req, vector[7:0], vector_valid
interface irr_isr_priority_resolver_if;
`ifdef PIC_AUTO_ROTATE_EN
    logic       auto_rotate;
`endif
    logic       init;
    logic [7:0] ir;
    logic       ltim;
    logic [7:0] imr;
    logic [7:0] base;
    logic       inta_n;
    logic       eoi;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] highest_priority;
    logic       int_req;
    logic [7:0] vector;
    logic       vector_valid;

    modport master (
`ifdef PIC_AUTO_ROTATE_EN
        output auto_rotate,
`endif
        output init, ir, ltim, imr, base, inta_n, eoi,
        input  irr, isr, highest_priority, int_req, vector, vector_valid
    );

    modport slave (
`ifdef PIC_AUTO_ROTATE_EN
        input  auto_rotate,
`endif
        input  init, ir, ltim, imr, base, inta_n, eoi,
        output irr, isr, highest_priority, int_req, vector, vector_valid
    );
endinterface

// File: rtl/irr_isr_priority_resolver.sv
// 8259-style IRR/ISR priority resolver with two-pulse INTA vectoring and EOI.
// Ports: clk, rst_n (async, active-low), bus (slave modport of the _if bundle).
// Optional macro PIC_AUTO_ROTATE_EN adds bus.auto_rotate: each EOI makes the
// cleared level lowest priority. Without it priority is fixed IR0 > ... > IR7.
module irr_isr_priority_resolver (
    input  logic                           clk,
    input  logic                           rst_n,
    irr_isr_priority_resolver_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK1,
        S_ACK2
    } ack_state_t;

    ack_state_t state;
    logic [7:0] irr_q;
    logic [7:0] isr_q;
    logic [7:0] ir_prev;
    logic       inta_prev;
    logic [2:0] lat_l;
    logic       lat_p;
    logic       int_req_q;
    logic [7:0] vector_q;
    logic       vv_q;
    logic [2:0] prio_base;

    // Search starts at the current highest-priority level and wraps; the
    // first set bit in that order wins. Returns {found, index}.
    function automatic logic [3:0] pick(input logic [7:0] req,
                                        input logic [2:0] start);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'h0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic [3:0] pend_pick;
    logic [3:0] isr_pick;
    logic       pend_found;
    logic [2:0] pend_idx;
    logic       isr_found;
    logic [2:0] isr_top;
    logic [2:0] pend_rank;
    logic [2:0] isr_rank;
    logic       qualify;
    logic       fall;
    logic       rise;
    logic       grant;
    logic       eoi_hit;
    logic [7:0] ir_rise;
    logic [7:0] irr_nxt;
    logic [7:0] grant_mask;
    logic [7:0] irr_clr;
    logic [7:0] eoi_mask;
    logic       unused_base;

    assign pend_pick  = pick(irr_q & ~bus.imr, prio_base);
    assign isr_pick   = pick(isr_q, prio_base);
    assign pend_found = pend_pick[3];
    assign pend_idx   = pend_pick[2:0];
    assign isr_found  = isr_pick[3];
    assign isr_top    = isr_pick[2:0];

    // Rank 0 is the current highest level; lower rank preempts.
    assign pend_rank = pend_idx - prio_base;
    assign isr_rank  = isr_top - prio_base;
    assign qualify   = pend_found && (!isr_found || pend_rank < isr_rank);

    assign fall = inta_prev && !bus.inta_n;
    assign rise = !inta_prev && bus.inta_n;

    // The request must still be there at pulse 2, otherwise it is spurious.
    assign grant   = (state == S_ACK1) && fall && lat_p && irr_q[lat_l];
    assign eoi_hit = bus.eoi && isr_found;

    // Masked lines do not latch edges: unmasking needs a fresh edge.
    assign ir_rise = bus.ir & ~ir_prev & ~bus.imr;
    assign irr_nxt = bus.ltim ? bus.ir : (irr_q | ir_rise);

    assign grant_mask = grant ? (8'h01 << lat_l) : 8'h00;
    assign irr_clr    = bus.ltim ? 8'h00 : grant_mask;
    assign eoi_mask   = eoi_hit ? (8'h01 << isr_top) : 8'h00;

    assign unused_base = ^bus.base[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            irr_q     <= 8'h00;
            isr_q     <= 8'h00;
            ir_prev   <= 8'h00;
            inta_prev <= 1'b1;
            lat_l     <= 3'd0;
            lat_p     <= 1'b0;
            int_req_q <= 1'b0;
            vector_q  <= 8'h00;
            vv_q      <= 1'b0;
        end else if (bus.init) begin
            state     <= S_IDLE;
            irr_q     <= 8'h00;
            isr_q     <= 8'h00;
            ir_prev   <= 8'h00;
            inta_prev <= 1'b1;
            lat_l     <= 3'd0;
            lat_p     <= 1'b0;
            int_req_q <= 1'b0;
            vector_q  <= 8'h00;
            vv_q      <= 1'b0;
        end else begin
            ir_prev   <= bus.ir;
            inta_prev <= bus.inta_n;
            irr_q     <= irr_nxt & ~irr_clr;
            // EOI and grant never touch the same bit: grant sets a level
            // above every in-service bit.
            isr_q     <= (isr_q & ~eoi_mask) | grant_mask;
            unique case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_ACK1;
                        lat_l <= pend_idx;
                        lat_p <= pend_found;
                    end else begin
                        int_req_q <= qualify;
                    end
                end
                S_ACK1: begin
                    if (fall) begin
                        state <= S_ACK2;
                        vv_q  <= 1'b1;
                        if (grant) begin
                            vector_q <= {bus.base[7:3], lat_l};
                        end else begin
                            vector_q <= {bus.base[7:3], 3'b111};
                        end
                    end
                end
                S_ACK2: begin
                    if (rise) begin
                        state     <= S_IDLE;
                        vv_q      <= 1'b0;
                        int_req_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PIC_AUTO_ROTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_base <= 3'd0;
        end else if (bus.init) begin
            prio_base <= 3'd0;
        end else if (eoi_hit && bus.auto_rotate) begin
            prio_base <= isr_top + 3'd1;
        end
    end
`else
    assign prio_base = 3'd0;
`endif

    assign bus.irr              = irr_q;
    assign bus.isr              = isr_q;
    assign bus.highest_priority = pend_idx;
    assign bus.int_req          = int_req_q;
    assign bus.vector           = vector_q;
    assign bus.vector_valid     = vv_q;
endmodule

// File: tb/tb_irr_isr_priority_resolver.sv
// Directed bench for irr_isr_priority_resolver: vectors go through a
// scoreboard queue checked by a monitor; register state is checked inline.
module tb_irr_isr_priority_resolver;
    logic clk;
    logic rst_n;

    irr_isr_priority_resolver_if bus();

    irr_isr_priority_resolver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] vec;
        logic [7:0] isr;
        logic [7:0] irr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic vv_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.vector_valid && !vv_prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_vector actual=%h required=none",
                         bus.vector);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.vector !== e.vec || bus.isr !== e.isr ||
                    bus.irr !== e.irr) begin
                    n_bad++;
                    $display("FAIL ack vec/isr/irr actual=%h/%h/%h required=%h/%h/%h",
                             bus.vector, bus.isr, bus.irr, e.vec, e.isr, e.irr);
                end
            end
        end
        vv_prev = bus.vector_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic ack(input logic [7:0] v, input logic [7:0] s,
                       input logic [7:0] r);
        exp_t e;
        bus.inta_n = 1'b0;
        tick(2);
        bus.inta_n = 1'b1;
        tick(2);
        e.vec = v;
        e.isr = s;
        e.irr = r;
        exp_q.push_back(e);
        bus.inta_n = 1'b0;
        tick(2);
        bus.inta_n = 1'b1;
        tick(2);
    endtask

    task automatic pulse_eoi();
        bus.eoi = 1'b1;
        tick(1);
        bus.eoi = 1'b0;
    endtask

    task automatic pulse_init();
        bus.init = 1'b1;
        tick(1);
        bus.init = 1'b0;
    endtask

    initial begin
`ifdef PIC_AUTO_ROTATE_EN
        bus.auto_rotate = 1'b0;
`endif
        rst_n      = 1'b0;
        bus.init   = 1'b0;
        bus.ir     = 8'h00;
        bus.ltim   = 1'b0;
        bus.imr    = 8'h01;
        bus.base   = 8'hD8;
        bus.inta_n = 1'b1;
        bus.eoi    = 1'b0;
        tick(2);
        check("rst_irr", bus.irr, 8'h00);
        check("rst_isr", bus.isr, 8'h00);
        check("rst_int_req", {7'b0, bus.int_req}, 8'h00);
        check("rst_vector", bus.vector, 8'h00);
        check("rst_vv", {7'b0, bus.vector_valid}, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // Edge mode, IR0 masked: IR3 wins.
        bus.ir = 8'b1000_1001;
        tick(1);
        check("edge_irr", bus.irr, 8'h88);
        check("edge_hp", {5'b0, bus.highest_priority}, 8'h03);
        check("int_req_lat1", {7'b0, bus.int_req}, 8'h00);
        tick(1);
        check("edge_int_req", {7'b0, bus.int_req}, 8'h01);
        ack(8'hDB, 8'h08, 8'h80);
        tick(2);
        check("int_req_after_ack", {7'b0, bus.int_req}, 8'h00);

        pulse_eoi();
        check("eoi_isr", bus.isr, 8'h00);
        tick(1);
        check("eoi_int_req", {7'b0, bus.int_req}, 8'h01);
        ack(8'hDF, 8'h80, 8'h00);

        // Unmask IR0 and give it a fresh edge; it preempts IR7 in service.
        bus.imr = 8'h00;
        bus.ir  = 8'h88;
        tick(1);
        bus.ir  = 8'h89;
        tick(2);
        check("ir0_int_req", {7'b0, bus.int_req}, 8'h01);
        ack(8'hD8, 8'h81, 8'h00);
        pulse_eoi();
        check("eoi_top_isr", bus.isr, 8'h80);
        pulse_eoi();
        pulse_eoi();
        check("eoi_empty_isr", bus.isr, 8'h00);

        // Level mode.
        bus.ir   = 8'h00;
        bus.ltim = 1'b1;
        pulse_init();
        bus.ir = 8'h01;
        tick(2);
        check("lvl_int_req", {7'b0, bus.int_req}, 8'h01);
        ack(8'hD8, 8'h01, 8'h01);
        bus.ir = 8'h00;
        tick(2);
        check("lvl_irr_drop", bus.irr, 8'h00);
        pulse_eoi();

        // Request withdrawn between the pulses: spurious IR7 vector.
        bus.ir = 8'h01;
        tick(2);
        bus.inta_n = 1'b0;
        tick(1);
        bus.ir = 8'h00;
        tick(1);
        bus.inta_n = 1'b1;
        tick(2);
        begin
            exp_t e;
            e.vec = 8'hDF;
            e.isr = 8'h00;
            e.irr = 8'h00;
            exp_q.push_back(e);
        end
        bus.inta_n = 1'b0;
        tick(2);
        bus.inta_n = 1'b1;
        tick(2);
        check("spur_int_req", {7'b0, bus.int_req}, 8'h00);

        // Lower-priority IR2 waits for EOI of IR0.
        bus.ir = 8'h01;
        tick(2);
        ack(8'hD8, 8'h01, 8'h01);
        bus.ir = 8'h04;
        tick(3);
        check("nest_irr", bus.irr, 8'h04);
        check("nest_int_req", {7'b0, bus.int_req}, 8'h00);
        pulse_eoi();
        check("nest_eoi_isr", bus.isr, 8'h00);
        tick(1);
        check("nest_int_req_eoi", {7'b0, bus.int_req}, 8'h01);

        // Init after pulse 1 aborts the sequence.
        bus.inta_n = 1'b0;
        tick(2);
        bus.inta_n = 1'b1;
        pulse_init();
        check("init_irr", bus.irr, 8'h00);
        check("init_isr", bus.isr, 8'h00);
        check("init_int_req", {7'b0, bus.int_req}, 8'h00);
        check("init_vector", bus.vector, 8'h00);
        check("init_vv", {7'b0, bus.vector_valid}, 8'h00);
        tick(2);
        ack(8'hDA, 8'h04, 8'h04);
        bus.ir = 8'h00;
        pulse_eoi();
        tick(1);

`ifdef PIC_AUTO_ROTATE_EN
        bus.ltim = 1'b0;
        bus.auto_rotate = 1'b1;
        pulse_init();
        bus.ir = 8'h03;
        tick(2);
        ack(8'hD8, 8'h01, 8'h02);
        bus.ir = 8'h02;
        tick(1);
        bus.ir = 8'h03;
        tick(1);
        check("rot_irr", bus.irr, 8'h03);
        pulse_eoi();
        tick(1);
        ack(8'hD9, 8'h02, 8'h01);
`endif

        tick(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_vectors actual=%0d required=0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irr_isr_priority_resolver.md
IRR_ISR_PRIORITY_RESOLVER -- requirements
Module: irr_isr_priority_resolver

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: init  in  1  synchronous clear, same effect as reset (ICW1 write).
REQ-004 SHALL have ports: ir  in  8  interrupt request lines IR7..IR0.
REQ-005 SHALL have ports: ltim  in  1  trigger mode: 0 = edge, 1 = level.
REQ-006 SHALL have ports: imr  in  8  mask; bit=1 masks that IR.
REQ-007 SHALL have ports: base  in  8  vector base (ICW2); only base[7:3] used.
REQ-008 SHALL have ports: inta_n  in  1  interrupt acknowledge, active-low, sampled on clk.
REQ-009 SHALL have ports: eoi  in  1  one-cycle non-specific end-of-interrupt pulse.
REQ-010 SHALL have ports: irr  out  8  interrupt request register.
REQ-011 SHALL have ports: isr  out  8  in-service register.
REQ-012 SHALL have ports: highest_priority  out  3  index of winning unmasked IRR bit (combinational).
REQ-013 SHALL have ports: int_req  out  1  interrupt to CPU.
REQ-014 SHALL have ports: vector  out  8, vector_valid  out  1  acknowledge vector and its qualifier.

Function
REQ-015 SHALL, in edge mode, set irr[n] one clock after ir[n] is sampled 0 then 1; hold it until accepted or cleared.
REQ-016 SHALL, in level mode, make irr[n] a registered copy of ir[n] (one-clock latency).
REQ-017 SHALL resolve priority with fixed order IR0 highest to IR7 lowest over irr & ~imr; output 0 when none pending.
REQ-018 SHALL assert int_req when a pending unmasked request has higher priority than every set isr bit; int_req rises one clock after the qualifying irr bit.
REQ-019 SHALL detect inta_n falling/rising edges by comparing the current sample with the previous one; the acknowledge sequence is two low pulses.
REQ-020 SHALL, on the pulse-1 falling edge, latch L = highest_priority and a pending flag P = any unmasked irr bit.
REQ-021 SHALL, on the pulse-2 falling edge, when P=1 and irr[L] is still set: drive vector = {base[7:3], L}, set isr[L], and clear irr[L] in edge mode.
REQ-022 SHALL treat any other pulse-2 condition as spurious: vector = {base[7:3], 3'b111} with isr unchanged.
REQ-023 SHALL hold vector_valid=1 from the pulse-2 falling edge until the pulse-2 rising edge.
REQ-024 SHALL, on the pulse-2 rising edge, drop int_req and vector_valid; int_req re-evaluates from the next clock.
REQ-025 SHALL keep int_req asserted from pulse 1 through pulse 2 regardless of ir changes.
REQ-026 SHALL, on eoi, clear the highest-priority set isr bit; eoi with isr=0 has no effect.
REQ-027 SHALL let a new ir edge arriving during an acknowledge set irr normally, without disturbing the latched L.
REQ-028 SHALL let init or rst_n mid-sequence abort the sequence and return the pulse counter to pulse 1.

Reset
REQ-029 SHALL, on rst_n=0 or init=1, clear irr, isr, int_req, vector_valid, vector=8'h00, pulse counter and the ir/inta_n history (ir history 0, inta_n history 1).

Configuration
REQ-030 SHALL, when PIC_AUTO_ROTATE_EN is defined, add input auto_rotate (1 bit); when it is 1, each eoi makes the cleared level lowest priority (level+1 mod 8 becomes highest).
REQ-031 SHALL, when PIC_AUTO_ROTATE_EN is not defined, omit the port and use fixed priority only.

Verification
REQ-032 Edge mode, imr=8'h01, base=8'hD8, ir=8'b10001001 -> int_req=1; two INTA pulses -> vector=8'hDB, isr=8'h08, irr=8'h80, int_req drops after pulse 2.
REQ-033 Then eoi -> isr=0 and int_req reasserts; next acknowledge -> vector=8'hDF; then imr=0 and a new ir0 edge -> vector=8'hD8.
REQ-034 Level mode, imr=0, ir=8'h01 held through both pulses -> vector=8'hD8, isr=8'h01; ir dropped afterwards -> irr=0.
REQ-035 Level mode, ir0 dropped between pulse 1 and pulse 2 -> spurious vector=8'hDF, isr=0.
REQ-036 isr=8'h01 in service with ir2 pending -> int_req stays 0 until eoi; init mid-sequence -> all outputs 0.
REQ-037 With PIC_AUTO_ROTATE_EN and auto_rotate=1, service ir0 then eoi, with ir0 and ir1 both pending -> vector=8'hD9.
